roi_sched: RTL and testbench



---
 rtl/roi_pkg.sv | 32 +++
 rtl/roi_sched_rr_arbiter.sv | 32 +++
 rtl/roi_sched.sv | 196 +++++++++++++++++++
 tb/tb_roi_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_pkg.sv
// roi_pkg: shared types and field constants for the ROI frame scheduler.
// Provides the scheduler state enum, coordinate field positions and pack_xy().
// Coordinate word layout: x in [26:16], y in [9:0], all other bits zero.
package roi_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_CHECK  = 3'd2,
        S_ARM    = 3'd3,
        S_ACTIVE = 3'd4,
        S_DONE   = 3'd5
    } sched_state_t;

    localparam int X_LSB = 16;
    localparam int X_MSB = 26;
    localparam int Y_LSB = 0;
    localparam int Y_MSB = 9;
    localparam int X_W   = X_MSB - X_LSB + 1;
    localparam int Y_W   = Y_MSB - Y_LSB + 1;

    // Build a coordinate word with every bit outside the x/y fields cleared.
    function automatic logic [31:0] pack_xy(input logic [X_W-1:0] x,
                                            input logic [Y_W-1:0] y);
        logic [31:0] w;
        w              = '0;
        w[X_MSB:X_LSB] = x;
        w[Y_MSB:Y_LSB] = y;
        return w;
    endfunction

endpackage

// File: rtl/roi_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin select over N requesters.
// Ports: req (request vector), ptr (highest-priority index), gnt (one-hot),
//        idx (binary index of gnt), any (at least one request present).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from ptr upwards, wrapping, and take the first set request.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/roi_sched.sv
// roi_sched: frame-level scheduler for the ROI datapath. Round-robin grants
// window requests, range-checks and normalizes corners, holds xy_0_o/xy_1_o
// for one full input frame and reports done/err to the granted requester.
// Ports: req_* (requester side), s_tvalid_i/s_tlast_i/roi_tlast_i (stream
// monitors), xy_*_o/roi_en_o (datapath control), done_*_o/busy_o (status).
// Optional: define ROI_WDOG_EN to bound ARM+ACTIVE to WDOG_CYC cycles.
module roi_sched
    import roi_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 800,
    parameter int HEIGHT    = 600,
    parameter int BIT_COORD = 32,
    parameter int WDOG_CYC  = 1000000
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ*BIT_COORD-1:0] req_xy0_i,
    input  logic [N_REQ*BIT_COORD-1:0] req_xy1_i,
    input  logic                       s_tvalid_i,
    input  logic                       s_tlast_i,
    input  logic                       roi_tlast_i,
    output logic [BIT_COORD-1:0]       xy_0_o,
    output logic [BIT_COORD-1:0]       xy_1_o,
    output logic                       roi_en_o,
    output logic                       done_valid_o,
    output logic [$clog2(N_REQ)-1:0]  done_id_o,
    output logic                       done_err_o,
    output logic                       busy_o
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT);

    sched_state_t state, state_nxt;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    sel_q;
    logic [N_REQ-1:0] sel_oh_q;
    logic [X_W-1:0]   xa_q, xb_q;
    logic [Y_W-1:0]   ya_q, yb_q;
    logic             seen_last;
    logic             err_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    logic [BIT_COORD-1:0] sel_xy0, sel_xy1;
    logic [X_W-1:0]       x_lo, x_hi;
    logic [Y_W-1:0]       y_lo, y_hi;
    logic                 bad;
    logic                 eof;
    logic                 wd_hit;
    logic                 hold;

    assign eof = s_tvalid_i & s_tlast_i;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_xy0 = req_xy0_i[sel_q*BIT_COORD +: BIT_COORD];
    assign sel_xy1 = req_xy1_i[sel_q*BIT_COORD +: BIT_COORD];

    // Range check and corner normalization on the latched job.
    assign bad  = (xa_q > X_MAX) || (xb_q > X_MAX) ||
                  (ya_q > Y_MAX) || (yb_q > Y_MAX);
    assign x_lo = (xa_q < xb_q) ? xa_q : xb_q;
    assign x_hi = (xa_q < xb_q) ? xb_q : xa_q;
    assign y_lo = (ya_q < yb_q) ? ya_q : yb_q;
    assign y_hi = (ya_q < yb_q) ? yb_q : ya_q;

    assign hold = (state == S_ARM) || (state == S_ACTIVE);

`ifdef ROI_WDOG_EN
    logic [31:0] wd_cnt;

    // Counter is zero on the first ARM cycle and counts every ARM/ACTIVE cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wd_cnt <= '0;
        end else if (hold) begin
            wd_cnt <= wd_cnt + 32'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_hit = hold && (wd_cnt == 32'(WDOG_CYC - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (arb_any) state_nxt = S_GRANT;
            // A requester that dropped valid before its grant cycle loses the slot.
            S_GRANT:  state_nxt = req_valid_i[sel_q] ? S_CHECK : S_IDLE;
            S_CHECK:  state_nxt = bad ? S_DONE : S_ARM;
            S_ARM:    if (wd_hit) state_nxt = S_DONE;
                      else if (eof) state_nxt = S_ACTIVE;
            S_ACTIVE: if (wd_hit || eof) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Job bookkeeping: selection, latched corners, RR pointer, error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_ptr    <= '0;
            sel_q     <= '0;
            sel_oh_q  <= '0;
            xa_q      <= '0;
            ya_q      <= '0;
            xb_q      <= '0;
            yb_q      <= '0;
            seen_last <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    sel_q    <= arb_idx;
                    sel_oh_q <= arb_gnt;
                    err_q    <= 1'b0;
                end
                S_GRANT: begin
                    xa_q   <= sel_xy0[X_MSB:X_LSB];
                    ya_q   <= sel_xy0[Y_MSB:Y_LSB];
                    xb_q   <= sel_xy1[X_MSB:X_LSB];
                    yb_q   <= sel_xy1[Y_MSB:Y_LSB];
                    rr_ptr <= (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
                end
                S_CHECK: begin
                    seen_last <= 1'b0;
                    err_q     <= bad;
                end
                S_ARM: begin
                    if (wd_hit) err_q <= 1'b1;
                end
                S_ACTIVE: begin
                    if (roi_tlast_i) seen_last <= 1'b1;
                    // tlast coincident with EOF still counts as seen.
                    if (wd_hit) err_q <= 1'b1;
                    else if (eof) err_q <= !(seen_last | roi_tlast_i);
                end
                default: ;
            endcase
        end
    end

    // Outputs, decoded from state and latched job.
    always_comb begin
        req_ready_o  = '0;
        xy_0_o       = '0;
        xy_1_o       = '0;
        roi_en_o     = 1'b0;
        done_valid_o = 1'b0;
        done_id_o    = '0;
        done_err_o   = 1'b0;
        busy_o       = (state != S_IDLE);
        if (state == S_GRANT) begin
            req_ready_o = sel_oh_q & req_valid_i;
        end
        if (hold || (state == S_CHECK && !bad)) begin
            xy_0_o = BIT_COORD'(pack_xy(x_lo, y_lo));
            xy_1_o = BIT_COORD'(pack_xy(x_hi, y_hi));
        end
        roi_en_o = hold;
        if (state == S_DONE) begin
            done_valid_o = 1'b1;
            done_id_o    = sel_q;
            done_err_o   = err_q;
        end
    end

endmodule

// File: tb/tb_roi_sched.sv
module tb_roi_sched;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_ready_o;
    logic [127:0] req_xy0_i;
    logic [127:0] req_xy1_i;
    logic         s_tvalid_i;
    logic         s_tlast_i;
    logic         roi_tlast_i;
    logic [31:0]  xy_0_o;
    logic [31:0]  xy_1_o;
    logic         roi_en_o;
    logic         done_valid_o;
    logic [1:0]   done_id_o;
    logic         done_err_o;
    logic         busy_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    roi_sched #(
        .N_REQ(4), .WIDTH(800), .HEIGHT(600), .BIT_COORD(32), .WDOG_CYC(100)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_xy0_i    (req_xy0_i),
        .req_xy1_i    (req_xy1_i),
        .s_tvalid_i   (s_tvalid_i),
        .s_tlast_i    (s_tlast_i),
        .roi_tlast_i  (roi_tlast_i),
        .xy_0_o       (xy_0_o),
        .xy_1_o       (xy_1_o),
        .roi_en_o     (roi_en_o),
        .done_valid_o (done_valid_o),
        .done_id_o    (done_id_o),
        .done_err_o   (done_err_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        int          req;
        int          xa, ya, xb, yb;
        int          tl_mode;   // 0: no roi_tlast, 1: mid-frame, 2: with EOF
        logic        bad;
        logic [31:0] exp_xy0;
        logic [31:0] exp_xy1;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] pk(input int x, input int y);
        return (32'(x) << 16) | 32'(y);
    endfunction

    task automatic eof_pulse(input logic with_tlast);
        s_tvalid_i  = 1'b1;
        s_tlast_i   = 1'b1;
        roi_tlast_i = with_tlast;
        tick();
        s_tvalid_i  = 1'b0;
        s_tlast_i   = 1'b0;
        roi_tlast_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'h0);
        chk({tag, "_xy0"},   xy_0_o, 32'h0);
        chk({tag, "_xy1"},   xy_1_o, 32'h0);
        chk({tag, "_en"},    32'(roi_en_o), 32'h0);
        chk({tag, "_done"},  32'(done_valid_o), 32'h0);
        chk({tag, "_busy"},  32'(busy_o), 32'h0);
    endtask

    task automatic do_reset();
        rst_n_i     = 1'b0;
        req_valid_i = '0;
        s_tvalid_i  = 1'b0;
        s_tlast_i   = 1'b0;
        roi_tlast_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        req_xy0_i[v.req*32 +: 32] = pk(v.xa, v.ya);
        req_xy1_i[v.req*32 +: 32] = pk(v.xb, v.yb);
        req_valid_i[v.req] = 1'b1;
        tick();                                    // GRANT
        chk({tag, "_grant"}, 32'(req_ready_o), 32'(4'b0001 << v.req));
        tick();                                    // CHECK
        req_valid_i = '0;
        chk({tag, "_chk_ready"}, 32'(req_ready_o), 32'h0);
        chk({tag, "_chk_en"}, 32'(roi_en_o), 32'h0);
        chk({tag, "_chk_xy0"}, xy_0_o, v.bad ? 32'h0 : v.exp_xy0);
        chk({tag, "_chk_xy1"}, xy_1_o, v.bad ? 32'h0 : v.exp_xy1);
        tick();
        if (!v.bad) begin                          // ARM
            chk({tag, "_arm_en"}, 32'(roi_en_o), 32'h1);
            eof_pulse(1'b0);                       // ACTIVE
            chk({tag, "_act_en"}, 32'(roi_en_o), 32'h1);
            chk({tag, "_act_xy0"}, xy_0_o, v.exp_xy0);
            chk({tag, "_act_xy1"}, xy_1_o, v.exp_xy1);
            if (v.tl_mode == 1) begin
                roi_tlast_i = 1'b1;
                tick();
                roi_tlast_i = 1'b0;
            end
            tick();
            chk({tag, "_act_done"}, 32'(done_valid_o), 32'h0);
            eof_pulse(v.tl_mode == 2);             // DONE
        end
        chk({tag, "_done_vld"}, 32'(done_valid_o), 32'h1);
        chk({tag, "_done_id"}, 32'(done_id_o), 32'(v.req));
        chk({tag, "_done_err"}, 32'(done_err_o), 32'(v.exp_err));
        chk({tag, "_done_en"}, 32'(roi_en_o), 32'h0);
        chk({tag, "_done_xy0"}, xy_0_o, 32'h0);
        tick();                                    // IDLE
        check_idle_outputs({tag, "_idle"});
    endtask

    initial begin
        int grants[$];
        int gcyc[$];
        int n_done;

        vecs[0] = '{0, 10, 20, 50, 60, 1, 1'b0, 32'h000A0014, 32'h0032003C, 1'b0};
        vecs[1] = '{1, 300, 400, 100, 200, 1, 1'b0, 32'h006400C8, 32'h012C0190, 1'b0};
        vecs[2] = '{2, 801, 5, 10, 10, 1, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[3] = '{3, 800, 600, 800, 0, 1, 1'b0, 32'h03200000, 32'h03200258, 1'b0};
        vecs[4] = '{0, 5, 7, 2, 9, 0, 1'b0, 32'h00020007, 32'h00050009, 1'b1};
        vecs[5] = '{1, 0, 601, 0, 0, 1, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[6] = '{2, 1, 1, 1, 1, 2, 1'b0, 32'h00010001, 32'h00010001, 1'b0};

        req_xy0_i = '0;
        req_xy1_i = '0;
        do_reset();
        check_idle_outputs("reset");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset while ACTIVE; requests arriving in ARM must be ignored.
        req_xy0_i[31:0] = pk(10, 20);
        req_xy1_i[31:0] = pk(50, 60);
        req_valid_i = 4'b0001;
        tick();
        tick();
        req_valid_i = '0;
        tick();                                    // ARM
        chk("rst_arm_en", 32'(roi_en_o), 32'h1);
        req_valid_i = 4'b1000;
        tick();
        chk("ign_ready0", 32'(req_ready_o), 32'h0);
        tick();
        chk("ign_ready1", 32'(req_ready_o), 32'h0);
        req_valid_i = '0;
        eof_pulse(1'b1);                           // ACTIVE
        chk("rst_act_en", 32'(roi_en_o), 32'h1);
        rst_n_i = 1'b0;
        tick();
        check_idle_outputs("rst_mid");
        rst_n_i = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_valid_o) n_done++;
        end
        chk("rst_no_done", 32'(n_done), 32'h0);

        // Round robin: all four requesting, out-of-range windows for short jobs.
        for (int k = 0; k < 4; k++) begin
            req_xy0_i[k*32 +: 32] = pk(801, 0);
            req_xy1_i[k*32 +: 32] = pk(0, 0);
        end
        do_reset();
        req_valid_i = 4'b1111;
        for (int c = 0; c < 60 && grants.size() < 5; c++) begin
            tick();
            if (req_ready_o != 4'b0000) begin
                chk("rr_onehot", 32'($countones(req_ready_o)), 32'h1);
                for (int k = 0; k < 4; k++) if (req_ready_o[k]) grants.push_back(k);
                gcyc.push_back(c);
            end
        end
        req_valid_i = '0;
        chk("rr_count", 32'(grants.size()), 32'h5);
        if (grants.size() == 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(i % 4));
            for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'h4);
        end
        tick();
        tick();

`ifdef ROI_WDOG_EN
        begin
            int cyc;
            do_reset();
            req_xy0_i[63:32] = pk(1, 2);
            req_xy1_i[63:32] = pk(3, 4);
            req_valid_i = 4'b0010;
            tick();
            tick();
            req_valid_i = '0;
            tick();                                // first ARM cycle
            chk("wd_arm_en", 32'(roi_en_o), 32'h1);
            cyc = 0;
            while (!done_valid_o && cyc < 300) begin
                tick();
                cyc++;
            end
            chk("wd_latency", 32'(cyc), 32'd100);
            chk("wd_err", 32'(done_err_o), 32'h1);
            chk("wd_id", 32'(done_id_o), 32'h1);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
